nn_frame_controller: RTL and testbench

Parametrised frame controller between the UART byte links and the neural-network core. It assembles a received byte stream into `N_IN` little-endian words of `WORD_W` bits and starts the network. It holds the start request until the network reports done, then sends the `OUT_W`-bit result back as bytes, LSB first. Added over the previous generation: configurable widths and depth, a receive inter-byte timeout, overrun reporting, a byte-wise TX handshake and a defined reset.

---
 rtl/nn_ctrl_pkg.sv | 11 +
 rtl/nn_frame_packer.sv | 58 +++++
 rtl/nn_frame_controller.sv | 94 +++++++++
 tb/tb_nn_frame_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared state encoding, default geometry and index-width helper
package nn_ctrl_pkg;
    typedef enum logic [2:0] {RX, RUN, TX_ISSUE, TX_GUARD, TX_WAIT} state_t;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_N_IN        = 9;
    localparam int DEF_OUT_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 100000;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/nn_frame_packer.sv
// nn_frame_packer: assembles strobed bytes into little-endian words of a frame,
// discarding a partial frame after an idle timeout.
module nn_frame_packer
    import nn_ctrl_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int N_IN        = DEF_N_IN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   strobe,
    input  logic [7:0]             data_byte,
    output logic [N_IN*WORD_W-1:0] frame,
    output logic                   full,
    output logic                   timeout
);
    localparam int BPW = WORD_W / 8;
    localparam int BW  = idx_w(BPW);
    localparam int WW  = idx_w(N_IN);
    localparam int TW  = idx_w(TIMEOUT_CYC + 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(BPW - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(N_IN - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

    logic [BW-1:0] byte_idx;
    logic [WW-1:0] word_idx;
    logic [TW-1:0] idle_cnt;
    logic          take, partial, byte_wrap;

    assign take      = enable && strobe;
    assign partial   = enable && (byte_idx != '0 || word_idx != '0);
    assign byte_wrap = byte_idx == BYTE_LAST;
    assign full      = take && byte_wrap && word_idx == WORD_LAST;
    // an arriving byte always beats the timeout in the same cycle
    assign timeout   = (TIMEOUT_CYC != 0) && partial && !take && idle_cnt == IDLE_LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx <= '0;
            word_idx <= '0;
            idle_cnt <= '0;
            frame    <= '0;
        end else begin
            if (take)
                frame[(int'(word_idx) * BPW + int'(byte_idx)) * 8 +: 8] <= data_byte;
            if (full || timeout) begin
                byte_idx <= '0;
                word_idx <= '0;
            end else if (take) begin
                byte_idx <= byte_wrap ? '0 : byte_idx + 1'b1;
                word_idx <= byte_wrap ? word_idx + 1'b1 : word_idx;
            end
            idle_cnt <= (take || timeout || !partial) ? '0 : idle_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/nn_frame_controller.sv
// nn_frame_controller: feeds assembled frames to the network core and returns
// its result over the byte-wise TX handshake, LSB first.
module nn_frame_controller
    import nn_ctrl_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int N_IN        = DEF_N_IN,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [N_IN*WORD_W-1:0] frame,
    output logic                   net_start,
    input  logic                   net_done,
    input  logic [OUT_W-1:0]       net_result,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   frame_done,
    output logic                   rx_timeout,
    output logic                   rx_overrun
);
    localparam int OUT_BYTES = OUT_W / 8;
    localparam int XW        = idx_w(OUT_BYTES);
    localparam logic [XW-1:0] TX_LAST = XW'(OUT_BYTES - 1);

    state_t           state, state_nx;
    logic [OUT_W-1:0] result, src;
    logic [XW-1:0]    tx_idx, sel_idx;
    logic [7:0]       sel_byte;
    logic             full, timeout, issue, last;

    nn_frame_packer #(.WORD_W(WORD_W), .N_IN(N_IN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (state == RX),
        .strobe    (rx_valid),
        .data_byte (rx_data),
        .frame     (frame),
        .full      (full),
        .timeout   (timeout)
    );

    // issue is decided one cycle ahead so tx_start is a registered pulse
    // landing in the TX_ISSUE cycle; the first byte comes straight off net_result
    always_comb begin
        last     = tx_idx == TX_LAST;
        issue    = !tx_busy && ((state == RUN && net_done) ||
                                (state == TX_ISSUE && !tx_start) ||
                                (state == TX_WAIT && !last));
        src      = (state == RUN) ? net_result : result;
        sel_idx  = (state == TX_WAIT) ? tx_idx + 1'b1 : tx_idx;
        sel_byte = src[int'(sel_idx) * 8 +: 8];
        state_nx = state;
        case (state)
            RX:       state_nx = full ? RUN : RX;
            RUN:      state_nx = net_done ? TX_ISSUE : RUN;
            TX_ISSUE: state_nx = tx_start ? TX_GUARD : TX_ISSUE;
            TX_GUARD: state_nx = TX_WAIT;
            TX_WAIT:  state_nx = tx_busy ? TX_WAIT : (last ? RX : TX_ISSUE);
            default:  state_nx = RX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RX;
            result     <= '0;
            tx_idx     <= '0;
            net_start  <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            rx_timeout <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            state      <= state_nx;
            net_start  <= state_nx == RUN;
            if (state == RUN && net_done)
                result <= net_result;
            tx_start   <= issue;
            if (issue)
                tx_data <= sel_byte;
            if (state == TX_WAIT && !tx_busy)
                tx_idx <= last ? '0 : tx_idx + 1'b1;
            frame_done <= state == TX_WAIT && !tx_busy && last;
            rx_timeout <= timeout;
            rx_overrun <= rx_valid && state != RX;
        end
    end
endmodule

// File: tb/tb_nn_frame_controller.sv
// tb_nn_frame_controller: directed checks of frame assembly, run/reply, multi-byte
// TX, timeout, overrun and asynchronous reset.
module tb_nn_frame_controller;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         rx_valid = 1'b0, feed16 = 1'b0;
    logic [7:0]   rx_data = '0;
    logic [287:0] frame8, frame16;
    logic         net_start8, net_done8 = 1'b0, tx_start8, tx_busy8 = 1'b0;
    logic         frame_done8, rx_timeout8, rx_overrun8;
    logic [7:0]   net_result8 = '0, tx_data8;
    logic         net_start16, net_done16 = 1'b0, tx_start16, tx_busy16 = 1'b0;
    logic         frame_done16, rx_timeout16, rx_overrun16;
    logic [15:0]  net_result16 = '0;
    logic [7:0]   tx_data16;
    logic [7:0]   txd16 [4];
    int total = 0, bad = 0;
    int n_tx8 = 0, n_fd8 = 0, n_to8 = 0, n_ov8 = 0;
    int n_tx16 = 0, n_fd16 = 0, viol16 = 0, bcnt16 = 0;

    always #5 clk = ~clk;

    nn_frame_controller #(.WORD_W(32), .N_IN(9), .OUT_W(8), .TIMEOUT_CYC(50)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .frame(frame8),
        .net_start(net_start8), .net_done(net_done8), .net_result(net_result8),
        .tx_start(tx_start8), .tx_data(tx_data8), .tx_busy(tx_busy8),
        .frame_done(frame_done8), .rx_timeout(rx_timeout8), .rx_overrun(rx_overrun8));

    nn_frame_controller #(.WORD_W(32), .N_IN(9), .OUT_W(16), .TIMEOUT_CYC(50)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid & feed16), .rx_data(rx_data), .frame(frame16),
        .net_start(net_start16), .net_done(net_done16), .net_result(net_result16),
        .tx_start(tx_start16), .tx_data(tx_data16), .tx_busy(tx_busy16),
        .frame_done(frame_done16), .rx_timeout(rx_timeout16), .rx_overrun(rx_overrun16));

    // pulse counters and a transmitter model for the 16-bit instance: busy for 10 cycles per byte
    always @(negedge clk) begin
        n_tx8  += int'(tx_start8);
        n_fd8  += int'(frame_done8);
        n_to8  += int'(rx_timeout8);
        n_ov8  += int'(rx_overrun8);
        n_fd16 += int'(frame_done16);
        if (tx_start16) begin
            if (tx_busy16) viol16++;
            if (n_tx16 < 4) txd16[n_tx16] = tx_data16;
            n_tx16++;
            bcnt16 = 10;
        end else if (bcnt16 > 0) begin
            bcnt16--;
        end
        tx_busy16 = bcnt16 != 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base);
        for (int i = 0; i < 36; i++) send(base + 8'(i));
    endtask

    task automatic run8(input string tag, input logic [7:0] r);
        int n;
        n = 0;
        net_done8   = 1'b1;
        net_result8 = r;
        step();
        net_done8 = 1'b0;
        while (!frame_done8 && n < 30) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(frame_done8), 64'd1);
        chk({tag, "_data"}, 64'(tx_data8), 64'(r));
    endtask

    initial begin
        int n, fd_before, tx_before, to_before, ov_before;
        repeat (3) step();
        chk("rst_frame", 64'(frame8[31:0]), 64'h0);
        chk("rst_outs", {net_start8, tx_start8, frame_done8, rx_timeout8, rx_overrun8}, 64'h0);
        chk("rst_txdata", 64'(tx_data8), 64'h0);
        rst_n = 1'b1;
        step();

        // full frame into both instances
        feed16 = 1'b1;
        for (int i = 0; i < 35; i++) send(8'(i));
        chk("start_early", 64'(net_start8), 64'd0);
        send(8'h23);
        feed16 = 1'b0;
        chk("start_rise8", 64'(net_start8), 64'd1);
        chk("start_rise16", 64'(net_start16), 64'd1);
        chk("word0", 64'(frame8[31:0]), 64'h03020100);
        chk("word4", 64'(frame8[159:128]), 64'h13121110);
        chk("word8", 64'(frame8[287:256]), 64'h23222120);
        chk("word8_16", 64'(frame16[287:256]), 64'h23222120);

        // run and single-byte reply
        net_done8   = 1'b1;
        net_result8 = 8'hA5;
        step();
        net_done8   = 1'b0;
        net_result8 = 8'h00;
        chk("start_fall", 64'(net_start8), 64'd0);
        chk("tx_pulse", 64'(tx_start8), 64'd1);
        chk("tx_a5", 64'(tx_data8), 64'hA5);
        tx_busy8 = 1'b1;
        repeat (4) step();
        chk("tx_single", 64'(tx_start8), 64'd0);
        chk("fd_while_busy", 64'(frame_done8), 64'd0);
        tx_busy8 = 1'b0;
        step();
        chk("fd_pulse", 64'(frame_done8), 64'd1);
        step();
        chk("fd_clear", 64'(frame_done8), 64'd0);
        chk("tx_count8", 64'(n_tx8), 64'd1);
        chk("fd_count8", 64'(n_fd8), 64'd1);
        chk("tx_hold", 64'(tx_data8), 64'hA5);

        // two-byte reply against a slow transmitter
        net_done16   = 1'b1;
        net_result16 = 16'hBEEF;
        step();
        net_done16   = 1'b0;
        net_result16 = 16'h0000;
        chk("start_fall16", 64'(net_start16), 64'd0);
        n = 0;
        while (n_fd16 == 0 && n < 80) begin
            step();
            n++;
        end
        chk("fd16", 64'(n_fd16), 64'd1);
        chk("tx_count16", 64'(n_tx16), 64'd2);
        chk("tx16_b0", 64'(txd16[0]), 64'hEF);
        chk("tx16_b1", 64'(txd16[1]), 64'hBE);
        chk("tx16_busy_viol", 64'(viol16), 64'd0);

        // timeout discards a partial frame
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
        repeat (49) step();
        chk("to_early", 64'(rx_timeout8), 64'd0);
        step();
        chk("to_pulse", 64'(rx_timeout8), 64'd1);
        step();
        chk("to_clear", 64'(rx_timeout8), 64'd0);
        chk("to_count", 64'(n_to8), 64'd1);
        send_frame(8'h40);
        chk("to_start", 64'(net_start8), 64'd1);
        chk("to_word0", 64'(frame8[31:0]), 64'h43424140);
        chk("to_word8", 64'(frame8[287:256]), 64'h63626160);
        run8("to_run", 8'h11);

        // byte on the 50th idle cycle suppresses the timeout and restarts the count
        for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
        repeat (49) step();
        send(8'h55);
        chk("sup_nopulse", 64'(rx_timeout8), 64'd0);
        repeat (49) step();
        chk("sup_count", 64'(n_to8), 64'd1);
        step();
        chk("sup_late_to", 64'(rx_timeout8), 64'd1);
        step();

        // overrun during RUN
        send_frame(8'h80);
        ov_before = n_ov8;
        send(8'hFF);
        chk("ov_pulse", 64'(rx_overrun8), 64'd1);
        send(8'hFE);
        send(8'hFD);
        step();
        chk("ov_count", 64'(n_ov8 - ov_before), 64'd3);
        chk("ov_word0", 64'(frame8[31:0]), 64'h83828180);
        chk("ov_word8", 64'(frame8[287:256]), 64'hA3A2A1A0);
        chk("ov_still_run", 64'(net_start8), 64'd1);
        run8("ov_run", 8'h22);

        // reset while waiting for the transmitter
        send_frame(8'hC0);
        net_done8   = 1'b1;
        net_result8 = 8'h5A;
        step();
        net_done8 = 1'b0;
        chk("rw_tx", 64'(tx_data8), 64'h5A);
        tx_busy8 = 1'b1;
        repeat (3) step();
        fd_before = n_fd8;
        tx_before = n_tx8;
        rst_n = 1'b0;
        #1;
        chk("rw_outs", {net_start8, tx_start8, frame_done8, rx_timeout8, rx_overrun8}, 64'h0);
        chk("rw_txdata", 64'(tx_data8), 64'h0);
        chk("rw_frame", 64'(frame8[31:0]), 64'h0);
        repeat (2) step();
        rst_n    = 1'b1;
        tx_busy8 = 1'b0;
        repeat (5) step();
        chk("rw_no_fd", 64'(n_fd8 - fd_before), 64'd0);
        chk("rw_no_tx", 64'(n_tx8 - tx_before), 64'd0);

        // reset in the middle of word 4
        for (int i = 0; i < 18; i++) send(8'hA0 + 8'(i));
        to_before = n_to8;
        rst_n = 1'b0;
        #1;
        chk("rr_word0", 64'(frame8[31:0]), 64'h0);
        chk("rr_word4", 64'(frame8[159:128]), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        send_frame(8'h10);
        chk("rr_start", 64'(net_start8), 64'd1);
        chk("rr_word0b", 64'(frame8[31:0]), 64'h13121110);
        chk("rr_word8b", 64'(frame8[287:256]), 64'h33323130);
        chk("rr_no_to", 64'(n_to8 - to_before), 64'd0);
        run8("rr_run", 8'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
